uop_sequencer: RTL and testbench

Sits between the instruction queue and the decode stage. It controls how each queued instruction enters decode:
- multi-result ops (HI/LO writers, MUL) go out as two consecutive micro-ops, with `dec_is_inst2` marking the second;
- privileged, ERET and conditional-move ops go out alone, only after the backend is empty, and nothing else enters decode until the redirect flush they cause arrives.

It holds the instruction-queue head until every micro-op of that instruction has been accepted.

---
 rtl/uop_sequencer_pkg.sv | 31 +++
 rtl/uop_sequencer_classify.sv | 34 +++
 rtl/uop_sequencer.sv | 137 +++++++++++++
 tb/tb_uop_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_sequencer_pkg.sv
// Shared core package: raw operation encoding, decoded instruction record and
// the micro-op sequencer state type.
//   operation_t    - raw operation from the instruction queue
//   decoded_inst_t - what decode hands to rename
//   seq_state_t    - uop_sequencer FSM state (2 bits)
package uop_sequencer_pkg;

  typedef enum logic [5:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT, OP_LW, OP_SW,
    OP_BEQ, OP_J, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU,
    OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL, OP_CACHE,
    OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR, OP_ERET, OP_MOVN, OP_MOVZ, OP_SYSCALL
  } operation_t;

  typedef struct packed {
    operation_t  op;
    logic        is_inst2;
    logic        ex;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } decoded_inst_t;

  typedef enum logic [1:0] {
    PASS        = 2'd0,
    SPLIT2      = 2'd1,
    DRAIN       = 2'd2,
    SERIAL_WAIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/uop_sequencer_classify.sv
// uop_classify: combinational issue-class decode of a raw operation.
//   operation - raw operation (operation_t)
//   ex        - instruction already carries an exception
//   is_split  - goes to decode as two micro-ops
//   is_serial - must issue alone into an empty backend
// An excepting instruction never executes, so it is always PLAIN.
module uop_classify
  import uop_sequencer_pkg::*;
(
  input  operation_t operation,
  input  logic       ex,
  output logic       is_split,
  output logic       is_serial
);

  always_comb begin
    is_split  = 1'b0;
    is_serial = 1'b0;
    case (operation)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU, OP_MUL:
        is_split = 1'b1;
      OP_CACHE, OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR, OP_ERET,
      OP_MOVN, OP_MOVZ:
        is_serial = 1'b1;
      default: ;
    endcase
    if (ex) begin
      is_split  = 1'b0;
      is_serial = 1'b0;
    end
  end

endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: controls how the instruction-queue head enters decode.
// Split ops go out as two micro-ops; serial ops wait for an empty backend,
// issue alone and then block decode until the redirect flush they cause.
//   clk, resetn      - clock, synchronous active-low reset
//   flush            - pipeline redirect, overrides everything
//   iq_valid/iq_operation/iq_ex/iq_ready - instruction queue head and pop
//   rob_empty        - nothing in flight past decode
//   dec_valid/dec_ready/dec_is_inst2     - micro-op offer to decode
//   seq_busy         - state is not PASS (also serves as FSM debug view)
//   perf_split_cnt   - split instructions accepted
//   perf_drain_cyc   - cycles spent in DRAIN
// Build option: define UOP_SEQ_PERF_EN to implement the counters; otherwise
// the counter ports read 0 and no counter flops exist.
//
// Handshake: a micro-op transfers when dec_valid && dec_ready (and no flush).
// dec_valid never depends on dec_ready; once offered, the micro-op and
// dec_is_inst2 hold until accepted. iq_ready pulses only on the handshake of
// the head's last micro-op.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              iq_valid,
  input  operation_t        iq_operation,
  input  logic              iq_ex,
  output logic              iq_ready,
  input  logic              rob_empty,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              dec_is_inst2,
  output logic              seq_busy,
  output logic [PERF_W-1:0] perf_split_cnt,
  output logic [PERF_W-1:0] perf_drain_cyc
);

  seq_state_t state, state_nxt;
  logic       is_split, is_serial;

  uop_classify u_classify (
    .operation (iq_operation),
    .ex        (iq_ex),
    .is_split  (is_split),
    .is_serial (is_serial)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= PASS;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    dec_valid    = 1'b0;
    dec_is_inst2 = 1'b0;
    iq_ready     = 1'b0;
    case (state)
      PASS: begin
        if (iq_valid) begin
          if (is_serial && !rob_empty) begin
            state_nxt = DRAIN;
          end else begin
            dec_valid = 1'b1;
            if (dec_ready) begin
              if (is_split) begin
                state_nxt = SPLIT2;
              end else begin
                iq_ready = 1'b1;
                if (is_serial) state_nxt = SERIAL_WAIT;
              end
            end
          end
        end
      end
      SPLIT2: begin
        // Head is still held by the queue, so no need to look at iq_valid.
        dec_valid    = 1'b1;
        dec_is_inst2 = 1'b1;
        if (dec_ready) begin
          iq_ready  = 1'b1;
          state_nxt = PASS;
        end
      end
      DRAIN: begin
        // Return to PASS rather than issuing directly: the serial op is
        // re-classified and issued on the next cycle.
        if (rob_empty) state_nxt = PASS;
      end
      SERIAL_WAIT: begin
        // Only the redirect of the serial op releases this state.
      end
      default: state_nxt = PASS;
    endcase

    if (flush) begin
      dec_valid = 1'b0;
      iq_ready  = 1'b0;
      state_nxt = PASS;
    end

    if (!resetn) begin
      dec_valid    = 1'b0;
      dec_is_inst2 = 1'b0;
      iq_ready     = 1'b0;
    end
  end

  assign seq_busy = (state != PASS);

`ifdef UOP_SEQ_PERF_EN
  logic [PERF_W-1:0] split_cnt_q, drain_cyc_q;

  // dec_valid is already cleared by flush, so a voided SPLIT2 handshake
  // does not count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      split_cnt_q <= '0;
      drain_cyc_q <= '0;
    end else begin
      if (state == SPLIT2 && dec_valid && dec_ready)
        split_cnt_q <= split_cnt_q + PERF_W'(1);
      if (state == DRAIN)
        drain_cyc_q <= drain_cyc_q + PERF_W'(1);
    end
  end

  assign perf_split_cnt = split_cnt_q;
  assign perf_drain_cyc = drain_cyc_q;
`else
  assign perf_split_cnt = '0;
  assign perf_drain_cyc = '0;
`endif

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: directed test-plan steps followed by a random
// phase, all checked cycle by cycle against a transaction-level model.
module tb_uop_sequencer;
  import uop_sequencer_pkg::*;

  localparam int PERF_W = 32;
  localparam int W = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn, flush, iq_valid, iq_ex, iq_ready, rob_empty;
  logic              dec_valid, dec_ready, dec_is_inst2, seq_busy;
  operation_t        iq_operation;
  logic [PERF_W-1:0] perf_split_cnt, perf_drain_cyc;

  uop_sequencer #(.PERF_W(PERF_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .iq_valid       (iq_valid),
    .iq_operation   (iq_operation),
    .iq_ex          (iq_ex),
    .iq_ready       (iq_ready),
    .rob_empty      (rob_empty),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_is_inst2   (dec_is_inst2),
    .seq_busy       (seq_busy),
    .perf_split_cnt (perf_split_cnt),
    .perf_drain_cyc (perf_drain_cyc)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];   // {op, is_inst2} of micro-ops expected to transfer
  logic [6:0]   iq_q[$];    // random-phase instruction queue: {ex, op}
  bit           rand_mode = 1'b0;

  // Model: how many micro-ops of the head are already accepted, whether decode
  // is blocked until a redirect, whether we are waiting for the backend.
  int      m_done = 0;
  bit      m_hold = 1'b0;
  bit      m_wait = 1'b0;
  longint  m_split = 0;
  longint  m_drain = 0;
  bit      last_pop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int op_uops(input operation_t op, input logic ex);
    if (ex) return 1;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU, OP_MUL: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit op_serial(input operation_t op, input logic ex);
    if (ex) return 1'b0;
    case (op)
      OP_CACHE, OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR, OP_ERET,
      OP_MOVN, OP_MOVZ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check outputs at the negedge against the model, then advance
  // the model, then move past the posedge so the caller can drive new inputs.
  task automatic cycle();
    bit     e_v, e_i2, e_pop, e_busy, n_hold, n_wait;
    int     n_done, uops;
    longint n_split, n_drain;
    logic [W-1:0] got;
    @(negedge clk);
    e_v = 0; e_i2 = 0; e_pop = 0;
    e_busy  = (m_done != 0) || m_hold || m_wait;
    n_done  = m_done; n_hold = m_hold; n_wait = m_wait;
    n_split = m_split;
    n_drain = m_drain + (m_wait ? 1 : 0);
    if (!m_hold) begin
      if (m_wait) begin
        if (rob_empty) n_wait = 0;
      end else if (iq_valid) begin
        uops = op_uops(iq_operation, iq_ex);
        if (m_done == 0 && op_serial(iq_operation, iq_ex) && !rob_empty) begin
          n_wait = 1;
        end else begin
          e_v  = 1;
          e_i2 = (m_done == 1);
          if (dec_ready) begin
            if (m_done + 1 == uops) begin
              e_pop  = 1;
              n_done = 0;
              if (uops == 2) n_split++;
              if (op_serial(iq_operation, iq_ex)) n_hold = 1;
            end else begin
              n_done = m_done + 1;
            end
          end
        end
      end
    end
    if (flush) begin
      e_v = 0; e_pop = 0;
      n_done = 0; n_hold = 0; n_wait = 0;
      n_split = m_split;
    end
    if (!resetn) begin
      e_v = 0; e_i2 = 0; e_pop = 0;
      n_done = 0; n_hold = 0; n_wait = 0;
      n_split = 0; n_drain = 0;
    end

    check("dec_valid", 64'(dec_valid), 64'(e_v));
    check("iq_ready", 64'(iq_ready), 64'(e_pop));
    if (!resetn || !flush) check("dec_is_inst2", 64'(dec_is_inst2), 64'(e_i2));
    if (resetn) check("seq_busy", 64'(seq_busy), 64'(e_busy));
`ifdef UOP_SEQ_PERF_EN
    check("perf_split_cnt", 64'(perf_split_cnt), 64'(PERF_W'(m_split)));
    check("perf_drain_cyc", 64'(perf_drain_cyc), 64'(PERF_W'(m_drain)));
`else
    check("perf_split_cnt", 64'(perf_split_cnt), 64'd0);
    check("perf_drain_cyc", 64'(perf_drain_cyc), 64'd0);
`endif

    // Transfer scoreboard.
    if (e_v && dec_ready) exp_q.push_back({iq_operation, e_i2});
    if (dec_valid && dec_ready && resetn && !flush) begin
      got = {iq_operation, dec_is_inst2};
      if (exp_q.size() == 0) check("sb_extra_uop", 64'(got), 64'd0);
      else check("sb_uop", 64'(got), 64'(exp_q.pop_front()));
    end

    last_pop = e_pop;
    m_done = n_done; m_hold = n_hold; m_wait = n_wait;
    m_split = n_split; m_drain = n_drain;

    if (rand_mode) begin
      if (!resetn || flush) iq_q.delete();
      else if (e_pop && iq_q.size() > 0) void'(iq_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input operation_t op, input logic ex,
                       input logic rob, input logic rdy, input logic fl);
    iq_valid = v; iq_operation = op; iq_ex = ex;
    rob_empty = rob; dec_ready = rdy; flush = fl;
  endtask

  task automatic drive_random();
    int n;
    if (iq_q.size() == 0 && $urandom_range(0, 2) == 0) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        iq_q.push_back({1'($urandom_range(0, 9) == 0), 6'($urandom_range(0, 31))});
    end
    iq_valid = (iq_q.size() > 0);
    if (iq_valid) begin
      iq_ex        = iq_q[0][6];
      iq_operation = operation_t'(iq_q[0][5:0]);
    end else begin
      iq_ex        = 1'($urandom_range(0, 1));
      iq_operation = operation_t'($urandom_range(0, 31));
    end
    rob_empty = ($urandom_range(0, 9) < 6);
    dec_ready = ($urandom_range(0, 3) != 0);
    flush     = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
    resetn    = ($urandom_range(0, 199) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pops;
    longint base;

    resetn = 1'b0;
    drive(1'b1, OP_MADD, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    cycle(); cycle();
    resetn = 1'b1;

    // 1: three ADDUs back to back.
    pops = 0;
    drive(1'b1, OP_ADDU, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin cycle(); pops += int'(last_pop); end
    check("t1_pops", 64'(pops), 64'd3);

    // 2: MADD with decode stalling on the second micro-op.
    pops = 0;
    base = m_split;
    drive(1'b1, OP_MADD, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(); pops += int'(last_pop);
    dec_ready = 1'b0;
    cycle(); pops += int'(last_pop);
    cycle(); pops += int'(last_pop);
    dec_ready = 1'b1;
    cycle(); pops += int'(last_pop);
    check("t2_pops", 64'(pops), 64'd1);
    check("t2_last_pop", 64'(last_pop), 64'd1);
    check("t2_split_delta", 64'(m_split - base), 64'd1);
    drive(1'b0, OP_NOP, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();

    // 3: TLBWI with a busy backend, then redirect, then next head.
    base = m_drain;
    drive(1'b1, OP_TLBWI, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    rob_empty = 1'b1;
    cycle();                      // rob_empty seen in DRAIN
    check("t3_drain_cycles", 64'(m_drain - base), 64'd5);
    cycle();                      // TLBWI issues and pops
    check("t3_serial_pop", 64'(last_pop), 64'd1);
    drive(1'b1, OP_ADDU, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(); cycle(); cycle();    // blocked in SERIAL_WAIT
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();                      // ADDU issues right after the flush
    check("t3_next_pop", 64'(last_pop), 64'd1);

    // 4: DIV with flush on the second handshake.
    base = m_split;
    drive(1'b1, OP_DIV, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    flush = 1'b1;
    cycle();
    check("t4_no_pop", 64'(last_pop), 64'd0);
    check("t4_split_delta", 64'(m_split - base), 64'd0);
    drive(1'b0, OP_NOP, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();

    // 5: MOVN carrying an exception issues as a plain op.
    drive(1'b1, OP_MOVN, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    check("t5_pop", 64'(last_pop), 64'd1);
    drive(1'b1, OP_ADDU, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    check("t5_no_block", 64'(last_pop), 64'd1);

    // 6: reset during SERIAL_WAIT.
    drive(1'b1, OP_TLBP, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, OP_NOP, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(); cycle();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    cycle();

    // Random phase.
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      cycle();
    end

    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
